// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the RX and TX sides.
//   rx_state_e        receiver FSM states
//   prescale_calc     clocks per oversample tick, rounded to nearest
//   majority_of_three 2-of-3 vote used for mid-bit sampling
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_e;

   function automatic int prescale_calc(input int clk_hz, input int baud, input int os);
      return (clk_hz + (baud * os) / 2) / (baud * os);
   endfunction

   function automatic logic majority_of_three(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: emits a one-cycle tick every Prescale clocks.
//   clk_i   core clock
//   reset_i synchronous active-high reset
//   clr_i   restarts the period so the next tick lands Prescale clocks later
//   tick_o  one-cycle tick
module uart_baud_tick #(
   parameter int Prescale = 17
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int W = Prescale > 1 ? $clog2(Prescale) : 1;

   logic [W-1:0] cnt;

   assign tick_o = cnt == W'(Prescale - 1);

   always_ff @(posedge clk_i)
      if (reset_i || clr_i || tick_o) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver, 16x oversampled, 3-sample mid-bit vote.
//   clk_i         core clock
//   reset_i       synchronous active-high reset
//   rx_i          raw asynchronous RX line, idle high
//   data_o        received byte, LSB first on the line
//   valid_o       data_o holds an unconsumed byte
//   ready_i       consumer takes data_o when valid_o & ready_i
//   framing_err_o one-cycle pulse: stop bit voted low
//   overrun_o     one-cycle pulse: byte completed while holding register full
//   busy_o        receiver FSM not idle
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter int ClkFreqHz  = 31_500_000,
   parameter int BaudRate   = 115_200,
   parameter int Oversample = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       framing_err_o,
   output logic       overrun_o,
   output logic       busy_o
);
   localparam int Prescale = prescale_calc(ClkFreqHz, BaudRate, Oversample);
   localparam int Half     = Oversample / 2;
   localparam int SW       = $clog2(Oversample);

   rx_state_e state, state_n;
   logic          sync1, rx_s, rx_prev, tick, v0, v1, maj;
   logic          start_det, vote, wrap, done, ferr;
   logic [SW-1:0] s, samp;
   logic [2:0]    nbit;
   logic [7:0]    shift;

   uart_baud_tick #(.Prescale(Prescale)) baud (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clr_i  (start_det),
      .tick_o (tick)
   );

   // The start-detect cycle is sample 0; samp is the index of the sample taken on this tick.
   assign samp      = (s == SW'(Oversample - 1)) ? '0 : s + 1'b1;
   assign start_det = state == IDLE && rx_prev && !rx_s;
   assign vote      = tick && samp == SW'(Half + 1);
   assign wrap      = tick && samp == '0;
   assign maj       = majority_of_three(v0, v1, rx_s);
   assign done      = state == STOP && vote && maj;
   assign ferr      = state == STOP && vote && !maj;
   assign busy_o    = state != IDLE;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start_det ? START : IDLE;
         START:   state_n = vote && maj ? IDLE : wrap ? DATA : START;
         DATA:    state_n = wrap && nbit == 3'd7 ? STOP : DATA;
         STOP:    state_n = vote ? (maj ? IDLE : WAIT_HI) : STOP;
         WAIT_HI: state_n = rx_s ? IDLE : WAIT_HI;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1         <= 1'b1;
         rx_s          <= 1'b1;
         rx_prev       <= 1'b1;
         state         <= IDLE;
         s             <= '0;
         nbit          <= '0;
         v0            <= 1'b0;
         v1            <= 1'b0;
         shift         <= '0;
         data_o        <= '0;
         valid_o       <= 1'b0;
         framing_err_o <= 1'b0;
         overrun_o     <= 1'b0;
      end else begin
         sync1         <= rx_i;
         rx_s          <= sync1;
         rx_prev       <= rx_s;
         state         <= state_n;
         framing_err_o <= ferr;
         overrun_o     <= done && valid_o && !ready_i;
         if (start_det) begin
            s    <= '0;
            nbit <= '0;
         end else if (tick) begin
            s <= samp;
            if (samp == SW'(Half - 1)) v0 <= rx_s;
            if (samp == SW'(Half)) v1 <= rx_s;
            if (state == DATA && vote) shift <= {maj, shift[7:1]};
            if (state == DATA && wrap) nbit <= nbit + 1'b1;
         end
         if (done && (!valid_o || ready_i)) begin
            data_o  <= shift;
            valid_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed self-checking bench for uart_rx_oversample at 16 clocks/bit.
module tb_uart_rx_oversample;
   logic       clk_i = 1'b0, reset_i = 1'b1, rx_i = 1'b1, ready_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o, framing_err_o, overrun_o, busy_o;
   int         checks = 0, fails = 0;
   int         n_ferr = 0, n_ovr = 0, n_both = 0;
   logic [7:0] beats[$];

   uart_rx_oversample #(.ClkFreqHz(1_600_000), .BaudRate(100_000), .Oversample(16)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .rx_i         (rx_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .framing_err_o(framing_err_o),
      .overrun_o    (overrun_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i)
      if (!reset_i) begin
         if (valid_o && ready_i) beats.push_back(data_o);
         if (framing_err_o) n_ferr++;
         if (overrun_o) n_ovr++;
         if (framing_err_o && overrun_o) n_both++;
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic send(input logic [7:0] b, input int cpb, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_i = f[i];
         step(cpb);
      end
      rx_i = 1'b1;
   endtask

   task automatic clear_log();
      beats.delete();
      n_ferr = 0;
      n_ovr  = 0;
   endtask

   initial begin
      logic [9:0] f77;
      step(3);
      check("rst_data", data_o, 8'h00);
      check("rst_valid", valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_ferr", framing_err_o, 1'b0);
      check("rst_ovr", overrun_o, 1'b0);
      reset_i = 1'b0;
      step(5);

      // 1: single byte with exact valid latency
      clear_log();
      fork
         send(8'hA5, 16, 1'b1);
         begin
            step(155);
            check("t1_busy_pre", busy_o, 1'b1);
            check("t1_valid_pre", valid_o, 1'b0);
            step(1);
            check("t1_valid_rise", valid_o, 1'b1);
            check("t1_data", data_o, 8'hA5);
            check("t1_busy_post", busy_o, 1'b0);
            step(1);
            check("t1_valid_drop", valid_o, 1'b0);
         end
      join
      step(10);
      check("t1_beats", beats.size(), 1);
      check("t1_ferr", n_ferr, 0);
      check("t1_ovr", n_ovr, 0);

      // 2: back-to-back frames
      clear_log();
      send(8'h00, 16, 1'b1);
      send(8'hFF, 16, 1'b1);
      send(8'h55, 16, 1'b1);
      step(20);
      check("t2_beats", beats.size(), 3);
      if (beats.size() == 3) begin
         check("t2_b0", beats[0], 8'h00);
         check("t2_b1", beats[1], 8'hFF);
         check("t2_b2", beats[2], 8'h55);
      end
      check("t2_ovr", n_ovr, 0);

      // 3: short glitch rejected at the start vote
      clear_log();
      rx_i = 1'b0;
      step(4);
      check("t3_busy_glitch", busy_o, 1'b1);
      rx_i = 1'b1;
      step(30);
      check("t3_busy_idle", busy_o, 1'b0);
      check("t3_beats", beats.size(), 0);
      check("t3_ferr", n_ferr, 0);

      // 4: framing error then recovery
      clear_log();
      send(8'h3C, 16, 1'b0);
      step(20);
      check("t4_ferr", n_ferr, 1);
      check("t4_beats_err", beats.size(), 0);
      send(8'h81, 16, 1'b1);
      step(20);
      check("t4_beats", beats.size(), 1);
      if (beats.size() == 1) check("t4_b0", beats[0], 8'h81);
      check("t4_ferr_after", n_ferr, 1);

      // 5: overrun while consumer stalls
      clear_log();
      ready_i = 1'b0;
      send(8'h11, 16, 1'b1);
      step(10);
      check("t5_valid", valid_o, 1'b1);
      check("t5_data", data_o, 8'h11);
      send(8'h22, 16, 1'b1);
      step(10);
      check("t5_data_held", data_o, 8'h11);
      check("t5_valid_held", valid_o, 1'b1);
      check("t5_ovr", n_ovr, 1);
      check("t5_ferr", n_ferr, 0);
      ready_i = 1'b1;
      step(3);
      check("t5_valid_drop", valid_o, 1'b0);
      check("t5_beats", beats.size(), 1);
      if (beats.size() == 1) check("t5_b0", beats[0], 8'h11);

      // 6: reset mid-frame during data bit 3 of 0x77
      clear_log();
      f77 = {1'b1, 8'h77, 1'b0};
      for (int i = 0; i < 4; i++) begin
         rx_i = f77[i];
         step(16);
      end
      rx_i = f77[4];
      step(8);
      check("t6_busy_frame", busy_o, 1'b1);
      reset_i = 1'b1;
      rx_i = 1'b1;
      step(1);
      check("t6_rst_data", data_o, 8'h00);
      check("t6_rst_valid", valid_o, 1'b0);
      check("t6_rst_busy", busy_o, 1'b0);
      step(20);
      check("t6_rst_ferr", framing_err_o, 1'b0);
      check("t6_rst_ovr", overrun_o, 1'b0);
      reset_i = 1'b0;
      step(20);
      check("t6_beats_none", beats.size(), 0);
      send(8'h42, 16, 1'b1);
      step(20);
      check("t6_beats", beats.size(), 1);
      if (beats.size() == 1) check("t6_b0", beats[0], 8'h42);
      check("t6_ferr", n_ferr, 0);

      // 7: bit period margin
      clear_log();
      send(8'hC3, 17, 1'b1);
      step(20);
      send(8'hC3, 15, 1'b1);
      step(20);
      check("t7_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         check("t7_slow", beats[0], 8'hC3);
         check("t7_fast", beats[1], 8'hC3);
      end
      check("t7_ferr", n_ferr, 0);
      check("both_pulses", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
